// File: rtl/ternary_issue_unit_if.sv
// Bundle between the ternary issue stage and its neighbours: the instruction
// source, the ternary ALU, the writeback observer and the debug read port.
// master = upstream/ALU/observer side, slave = the issue unit.
interface ternary_issue_unit_if #(
  parameter int WORD_SIZE = 9
);
  logic                     instr_valid;
  logic                     instr_ready;
  logic [17:0]              instr;
  logic [5:0]               alu_opcode;
  logic [2*WORD_SIZE-1:0]   alu_input1;
  logic [2*WORD_SIZE-1:0]   alu_input2;
  logic                     alu_enable;
  logic [2*WORD_SIZE-1:0]   alu_out;
  logic                     wb_valid;
  logic [3:0]               wb_addr;
  logic [2*WORD_SIZE-1:0]   wb_data;
  logic                     instr_error;
  logic [3:0]               dbg_addr;
  logic [2*WORD_SIZE-1:0]   dbg_data;

  modport master (
    output instr_valid, instr, alu_out, dbg_addr,
    input  instr_ready, alu_opcode, alu_input1, alu_input2, alu_enable,
           wb_valid, wb_addr, wb_data, instr_error, dbg_data
  );

  modport slave (
    input  instr_valid, instr, alu_out, dbg_addr,
    output instr_ready, alu_opcode, alu_input1, alu_input2, alu_enable,
           wb_valid, wb_addr, wb_data, instr_error, dbg_data
  );
endinterface

// File: rtl/ternary_issue_unit.sv
// Decode / operand-issue stage feeding ternary_alu. Holds a 9-entry ternary
// register file, issues one instruction per 3 cycles and writes the ALU
// result back. Trits: 2'b11 = -1, 2'b00 = 0, 2'b01 = +1, 2'b10 illegal.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | ready for an instruction; decode happens on the accept edge
//   S_ISSUE | ALU strobe high, operand buses valid
//   S_EXEC  | ALU result valid; written back on the edge that ends it
//   S_ERROR | one-cycle illegal-instruction pulse, nothing else touched
module ternary_issue_unit #(
  parameter int WORD_SIZE   = 9,
  parameter int INSTR_TRITS = 9
) (
  input logic           clock,
  input logic           reset_n,
  ternary_issue_unit_if.slave bus
);

  localparam int DW = 2 * WORD_SIZE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_EXEC,
    S_ERROR
  } state_t;

  state_t        state;
  logic [DW-1:0] rf [0:8];
  logic [3:0]    rd_idx;

  logic          has_bad_trit;
  logic [4:0]    op_val;
  logic          op_legal;
  logic          op_imm;
  logic [3:0]    rd_dec;
  logic [3:0]    rs1_dec;
  logic [3:0]    rs2_dec;
  logic [DW-1:0] operand1;
  logic [DW-1:0] operand2;

  // Opcode trits read as base-3 digits with -1 standing for digit 2,
  // so ADD (7 = 0,2,1) is 6'b00_11_01.
  function automatic logic [4:0] op_digit(input logic [1:0] t);
    case (t)
      2'b01:   op_digit = 5'd1;
      2'b11:   op_digit = 5'd2;
      default: op_digit = 5'd0;
    endcase
  endfunction

  // Balanced trit biased to 0..2 so a 2-trit register field maps to v+4.
  function automatic logic [3:0] trit_bias(input logic [1:0] t);
    case (t)
      2'b11:   trit_bias = 4'd0;
      2'b01:   trit_bias = 4'd2;
      default: trit_bias = 4'd1;
    endcase
  endfunction

  function automatic logic [3:0] reg_index(input logic [3:0] f);
    reg_index = trit_bias(f[3:2]) * 4'd3 + trit_bias(f[1:0]);
  endfunction

  // Decode of the instruction currently on the bus; only used on the accept edge.
  always_comb begin
    has_bad_trit = 1'b0;
    for (int i = 0; i < INSTR_TRITS; i++) begin
      if (bus.instr[2*i +: 2] == 2'b10) has_bad_trit = 1'b1;
    end
    op_val = op_digit(bus.instr[17:16]) * 5'd9
           + op_digit(bus.instr[15:14]) * 5'd3
           + op_digit(bus.instr[13:12]);
    case (op_val)
      5'd0, 5'd2, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
      5'd11, 5'd12, 5'd13, 5'd14, 5'd15: op_legal = 1'b1;
      default:                           op_legal = 1'b0;
    endcase
    op_imm   = (op_val >= 5'd12) && (op_val <= 5'd15);
    rd_dec   = reg_index(bus.instr[11:8]);
    rs1_dec  = reg_index(bus.instr[7:4]);
    rs2_dec  = reg_index(bus.instr[3:0]);
    operand1 = rf[rs1_dec];
    // Balanced ternary sign extension is plain zero fill.
    operand2 = op_imm ? {{(DW-4){1'b0}}, bus.instr[3:0]} : rf[rs2_dec];
  end

  // Sequencer, register file and all registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      rd_idx          <= 4'd0;
      for (int i = 0; i < 9; i++) rf[i] <= '0;
      bus.instr_ready <= 1'b1;
      bus.alu_enable  <= 1'b0;
      bus.wb_valid    <= 1'b0;
      bus.instr_error <= 1'b0;
      bus.alu_opcode  <= 6'd0;
      bus.alu_input1  <= '0;
      bus.alu_input2  <= '0;
      bus.wb_addr     <= 4'd0;
      bus.wb_data     <= '0;
    end else begin
      bus.alu_enable  <= 1'b0;
      bus.wb_valid    <= 1'b0;
      bus.instr_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            bus.instr_ready <= 1'b0;
            if (has_bad_trit || !op_legal) begin
              state           <= S_ERROR;
              bus.instr_error <= 1'b1;
            end else begin
              state          <= S_ISSUE;
              bus.alu_enable <= 1'b1;
              bus.alu_opcode <= bus.instr[17:12];
              bus.alu_input1 <= operand1;
              bus.alu_input2 <= operand2;
              rd_idx         <= rd_dec;
            end
          end
        end
        S_ISSUE: state <= S_EXEC;
        S_EXEC: begin
          // Index 4 is the hard-wired zero register: the write is dropped
          // but the writeback is still reported.
          if (rd_idx != 4'd4) rf[rd_idx] <= bus.alu_out;
          bus.wb_valid    <= 1'b1;
          bus.wb_addr     <= rd_idx;
          bus.wb_data     <= bus.alu_out;
          bus.instr_ready <= 1'b1;
          state           <= S_IDLE;
        end
        S_ERROR: begin
          bus.instr_ready <= 1'b1;
          state           <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Debug read port, out-of-range indices read as zero.
  always_comb begin
    bus.dbg_data = '0;
    if (bus.dbg_addr <= 4'd8) bus.dbg_data = rf[bus.dbg_addr];
  end

endmodule

// File: tb/tb_ternary_issue_unit.sv
// Bench for ternary_issue_unit: a behavioural ALU drives alu_out, and an
// integer-level register model predicts operands, results and writebacks.
module tb_ternary_issue_unit;
  localparam int W  = 4;
  localparam int DW = 2 * W;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  ternary_issue_unit_if #(.WORD_SIZE(W)) bus ();
  ternary_issue_unit #(.WORD_SIZE(W), .INSTR_TRITS(9)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_accept = 0;
  logic [DW-1:0] mreg [9];

  typedef struct {
    logic [17:0] ins;
    bit          err;
    logic [3:0]  addr;
    int          val;
  } vec_t;
  vec_t tbl [12];

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int tv(input logic [1:0] t);
    if (t == 2'b01) return 1;
    if (t == 2'b11) return -1;
    return 0;
  endfunction

  function automatic logic [1:0] tenc(input int v);
    if (v > 0) return 2'b01;
    if (v < 0) return 2'b11;
    return 2'b00;
  endfunction

  function automatic int to_int(input logic [DW-1:0] w);
    int s = 0;
    int p = 1;
    for (int i = 0; i < W; i++) begin
      s += tv(w[2*i +: 2]) * p;
      p *= 3;
    end
    return s;
  endfunction

  function automatic logic [DW-1:0] from_int(input int v);
    logic [DW-1:0] w = '0;
    int m = 1;
    int r, t, half;
    for (int i = 0; i < W; i++) m *= 3;
    half = (m - 1) / 2;
    v = (((v + half) % m) + m) % m - half;
    for (int i = 0; i < W; i++) begin
      r = ((v % 3) + 3) % 3;
      t = (r == 2) ? -1 : r;
      w[2*i +: 2] = tenc(t);
      v = (v - t) / 3;
    end
    return w;
  endfunction

  function automatic int op_value(input logic [5:0] o);
    int d [3];
    for (int i = 0; i < 3; i++) d[i] = (o[2*i +: 2] == 2'b11) ? 2 : tv(o[2*i +: 2]);
    return d[2] * 9 + d[1] * 3 + d[0];
  endfunction

  function automatic bit op_legal(input int v);
    return v inside {0, 2, 4, 5, 6, 7, 8, 11, 12, 13, 14, 15};
  endfunction

  function automatic logic [5:0] op_enc(input int v);
    logic [5:0] o;
    int d;
    for (int i = 0; i < 3; i++) begin
      d = v % 3;
      o[2*i +: 2] = (d == 2) ? 2'b11 : ((d == 1) ? 2'b01 : 2'b00);
      v = v / 3;
    end
    return o;
  endfunction

  function automatic logic [3:0] reg_enc(input int v);
    int r  = ((v % 3) + 3) % 3;
    int t0 = (r == 2) ? -1 : r;
    int t1 = (v - t0) / 3;
    return {tenc(t1), tenc(t0)};
  endfunction

  function automatic int reg_idx(input logic [3:0] f);
    return tv(f[3:2]) * 3 + tv(f[1:0]) + 4;
  endfunction

  function automatic logic [17:0] mk(input int op, input int rd, input int rs1, input int rs2);
    return {op_enc(op), reg_enc(rd), reg_enc(rs1), reg_enc(rs2)};
  endfunction

  // Behavioural ALU; shifts use the immediate value clamped to 0..W.
  function automatic logic [DW-1:0] alu_fn(input logic [5:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [DW-1:0] r = '0;
    int x = to_int(a);
    int y = to_int(b);
    int k = (y < 0) ? 0 : ((y > W) ? W : y);
    int p, q;
    case (op_value(op))
      0:       r = a;
      2:       r = from_int(-x);
      7, 13:   r = from_int(x + y);
      8:       r = from_int(x - y);
      11:      r = from_int((x == y) ? 1 : 0);
      4, 5, 6, 12: begin
        for (int i = 0; i < W; i++) begin
          p = tv(a[2*i +: 2]);
          q = tv(b[2*i +: 2]);
          case (op_value(op))
            5:       r[2*i +: 2] = tenc((p > q) ? p : q);
            6:       r[2*i +: 2] = tenc(-(p * q));
            default: r[2*i +: 2] = tenc((p < q) ? p : q);
          endcase
        end
      end
      14: for (int i = 0; i < W; i++) if (i + k < W) r[2*i +: 2] = a[2*(i+k) +: 2];
      15: for (int i = 0; i < W; i++) if (i >= k) r[2*i +: 2] = a[2*(i-k) +: 2];
      default: r = '0;
    endcase
    return r;
  endfunction

  // Stand-in for ternary_alu: registered result one cycle after the strobe.
  always @(posedge clock) begin
    if (!reset_n) bus.alu_out <= '0;
    else if (bus.alu_enable) bus.alu_out <= alu_fn(bus.alu_opcode, bus.alu_input1, bus.alu_input2);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      bus.dbg_addr = 4'(i);
      @(negedge clock);
      if (i < 9) check($sformatf("%s_dbg%0d", tag, i), bus.dbg_data, mreg[i]);
      else check($sformatf("%s_dbg%0d", tag, i), bus.dbg_data, 0);
    end
  endtask

  task automatic run_instr(input logic [17:0] ins, output bit got_err,
                           output logic [3:0] got_addr, output logic [DW-1:0] got_data);
    bit bad = 1'b0;
    int opv, rd, rs1, rs2, waited;
    logic [DW-1:0] e1, e2, eres;
    for (int i = 0; i < 9; i++) if (ins[2*i +: 2] == 2'b10) bad = 1'b1;
    opv  = op_value(ins[17:12]);
    bad  = bad || !op_legal(opv);
    rd   = reg_idx(ins[11:8]);
    rs1  = reg_idx(ins[7:4]);
    rs2  = reg_idx(ins[3:0]);
    e1   = mreg[rs1];
    e2   = (opv >= 12 && opv <= 15) ? from_int(tv(ins[3:2]) * 3 + tv(ins[1:0])) : mreg[rs2];
    eres = alu_fn(ins[17:12], e1, e2);
    got_err = 1'b0; got_addr = 4'd0; got_data = '0;
    waited = 0;
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    while (!bus.instr_ready && waited < 20) begin
      @(posedge clock); #1;
      waited++;
    end
    if (!bus.instr_ready) begin
      check("accept_timeout", 0, 1);
      bus.instr_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    last_accept = cyc;
    bus.instr_valid = 1'b0;
    check("ready_busy", bus.instr_ready, 0);
    got_err = bus.instr_error;
    if (bad) begin
      check("err_pulse", bus.instr_error, 1);
      check("err_no_alu", bus.alu_enable, 0);
      @(posedge clock); #1;
      check("err_pulse_end", bus.instr_error, 0);
      check("err_no_wb", bus.wb_valid, 0);
      check("err_no_alu2", bus.alu_enable, 0);
      check("err_ready_back", bus.instr_ready, 1);
    end else begin
      check("issue_en", bus.alu_enable, 1);
      check("issue_noerr", bus.instr_error, 0);
      check("issue_op", bus.alu_opcode, ins[17:12]);
      check("issue_in1", bus.alu_input1, e1);
      check("issue_in2", bus.alu_input2, e2);
      @(posedge clock); #1;
      check("exec_en_low", bus.alu_enable, 0);
      check("exec_no_wb", bus.wb_valid, 0);
      @(posedge clock); #1;
      check("wb_valid", bus.wb_valid, 1);
      check("wb_addr", bus.wb_addr, rd);
      check("wb_data", bus.wb_data, eres);
      check("wb_ready", bus.instr_ready, 1);
      check("wb_en_low", bus.alu_enable, 0);
      got_addr = bus.wb_addr;
      got_data = bus.wb_data;
      if (rd != 4) mreg[rd] = eres;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          e;
    logic [3:0]  a;
    logic [DW-1:0] d;
    logic [17:0] ins_bad;
    int          prev_accept;
    int          ops [12] = '{0, 2, 4, 5, 6, 7, 8, 11, 12, 13, 14, 15};
    bit          saw_wb;

    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.dbg_addr    = 4'd0;
    for (int i = 0; i < 9; i++) mreg[i] = '0;

    ins_bad = mk(7, 1, 1, 1);
    ins_bad[17:16] = 2'b10;
    tbl[0]  = '{mk(13,  1,  0, 1), 1'b0, 4'd5, 1};
    tbl[1]  = '{mk( 7,  1,  1, 1), 1'b0, 4'd5, 2};
    tbl[2]  = '{mk(13,  2,  0, 4), 1'b0, 4'd6, 4};
    tbl[3]  = '{mk(11, -1,  2, 2), 1'b0, 4'd3, 1};
    tbl[4]  = '{mk(11,  3,  1, 2), 1'b0, 4'd7, 0};
    tbl[5]  = '{mk( 7,  0,  1, 2), 1'b0, 4'd4, 6};
    tbl[6]  = '{ins_bad,           1'b1, 4'd0, 0};
    tbl[7]  = '{mk( 1,  1,  1, 1), 1'b1, 4'd0, 0};
    tbl[8]  = '{mk( 8, -4,  2, 1), 1'b0, 4'd0, 2};
    tbl[9]  = '{mk(15, -3,  1, 1), 1'b0, 4'd1, 6};
    tbl[10] = '{mk( 2, -2,  2, 0), 1'b0, 4'd2, -4};
    tbl[11] = '{mk(14,  4, -3, 1), 1'b0, 4'd8, 2};

    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    check("rst_ready", bus.instr_ready, 1);
    check("rst_en", bus.alu_enable, 0);
    check("rst_wb", bus.wb_valid, 0);
    check("rst_err", bus.instr_error, 0);
    check("rst_op", bus.alu_opcode, 0);
    check("rst_in1", bus.alu_input1, 0);
    check("rst_in2", bus.alu_input2, 0);
    check("rst_wb_addr", bus.wb_addr, 0);
    check("rst_wb_data", bus.wb_data, 0);

    prev_accept = 0;
    for (int i = 0; i < 12; i++) begin
      run_instr(tbl[i].ins, e, a, d);
      check($sformatf("tbl%0d_err", i), e, tbl[i].err);
      if (!tbl[i].err) begin
        check($sformatf("tbl%0d_addr", i), a, tbl[i].addr);
        check($sformatf("tbl%0d_val", i), d, from_int(tbl[i].val));
      end
      if (i == 1) check("b2b_gap", last_accept - prev_accept, 3);
      prev_accept = last_accept;
      if (i == 5 || i == 7) check_regs($sformatf("tbl%0d", i));
    end
    check_regs("tbl_end");

    // Reset asserted during ISSUE: the in-flight instruction must vanish.
    bus.instr = mk(13, 3, 0, 1);
    bus.instr_valid = 1'b1;
    @(posedge clock); #1;
    bus.instr_valid = 1'b0;
    check("mid_issue_en", bus.alu_enable, 1);
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    check("mid_rst_ready", bus.instr_ready, 1);
    check("mid_rst_en", bus.alu_enable, 0);
    check("mid_rst_op", bus.alu_opcode, 0);
    check("mid_rst_in1", bus.alu_input1, 0);
    check("mid_rst_wb_data", bus.wb_data, 0);
    saw_wb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      if (bus.wb_valid) saw_wb = 1'b1;
    end
    check("mid_rst_no_wb", saw_wb, 0);
    for (int i = 0; i < 9; i++) mreg[i] = '0;
    check_regs("mid_rst");

    // Randomised instruction stream against the register model.
    for (int n = 0; n < 160; n++) begin
      logic [17:0] ins;
      int op;
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 26)) : ops[$urandom_range(0, 11)];
      ins = mk(op, int'($urandom_range(0, 8)) - 4, int'($urandom_range(0, 8)) - 4,
               int'($urandom_range(0, 8)) - 4);
      if ($urandom_range(0, 19) == 0) begin
        int pos = int'($urandom_range(0, 8));
        ins[2*pos +: 2] = 2'b10;
      end
      run_instr(ins, e, a, d);
      if (n % 40 == 39) check_regs($sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
